// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
//   state_t      : controller FSM states (RUN, DRAIN, HALTED)
//   stage_ctrl_t : {wren, clr} pair driven to one pipeline register
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Cycles needed for HLT to travel from ID/EX to retirement (EX, MEM, WB).
    localparam int DRAIN_CYCLES_DEF = 3;

    typedef struct packed {
        logic wren;
        logic clr;
    } stage_ctrl_t;

    // Register held: no write, no clear.
    localparam stage_ctrl_t STAGE_HOLD = '{wren: 1'b0, clr: 1'b0};
    // Register advances normally.
    localparam stage_ctrl_t STAGE_RUN  = '{wren: 1'b1, clr: 1'b0};
    // Register loads a bubble.
    localparam stage_ctrl_t STAGE_BUBBLE = '{wren: 1'b1, clr: 1'b1};

    // Build a stage control pair from its two bits.
    function automatic stage_ctrl_t mk_stage(input logic wren, input logic clr);
        stage_ctrl_t s;
        s.wren = wren;
        s.clr  = clr;
        return s;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the instruction in ID and a load in EX.
// Ports:
//   id_rs, id_rt         : source registers of the ID instruction
//   id_uses_rs/_rt       : ID instruction actually reads that source
//   ex_mem_read, ex_rd   : EX instruction is a load, and its destination
//   load_use_stall       : ID must wait one cycle for the load data
module hazard_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 4
) (
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  load_use_stall
);

    logic rs_hit_s;
    logic rt_hit_s;
    logic rd_live_s;

    // Register 0 is hard-wired, so a load targeting it never produces a dependency.
    assign rd_live_s = (ex_rd != {REG_ADDR_W{1'b0}});
    assign rs_hit_s  = id_uses_rs && (id_rs == ex_rd);
    assign rt_hit_s  = id_uses_rt && (id_rt == ex_rd);

    assign load_use_stall = ex_mem_read && rd_live_s && (rs_hit_s || rt_hit_s);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Drives wren/clr for IF/ID, ID/EX, EX/MEM, MEM/WB and the PC write enable.
// Resolves D-cache freeze, load-use, taken branch, HLT drain and I-cache miss,
// in that priority, and counts stalled (pc_wren=0, not halted) cycles.
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   id_*, ex_*                    : hazard inputs from ID and EX
//   id_branch_taken, id_halt      : control-flow events decoded in ID
//   icache_miss, dcache_miss      : cache not-ready indications
//   pc_wren, *_wren, *_clr        : combinational pipeline controls
//   halted                        : processor has fully drained after HLT
//   stall_count                   : saturating stalled-cycle counter
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = 4,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  id_branch_taken,
    input  logic                  id_halt,
    input  logic                  icache_miss,
    input  logic                  dcache_miss,
    output logic                  pc_wren,
    output logic                  ifid_wren,
    output logic                  ifid_clr,
    output logic                  idex_wren,
    output logic                  idex_clr,
    output logic                  exmem_wren,
    output logic                  exmem_clr,
    output logic                  memwb_wren,
    output logic                  memwb_clr,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    state_t               state_r;
    state_t               state_next_s;
    logic [DRAIN_W-1:0]   drain_cnt_r;
    logic [DRAIN_W-1:0]   drain_cnt_next_s;
    logic [CNT_W-1:0]     stall_count_r;
    logic                 load_use_s;
    logic                 pc_wren_s;
    stage_ctrl_t          ifid_s;
    stage_ctrl_t          idex_s;
    stage_ctrl_t          exmem_s;
    stage_ctrl_t          memwb_s;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .load_use_stall (load_use_s)
    );

    // Next-state and priority mux for the pipeline controls.
    always_comb begin
        state_next_s     = state_r;
        drain_cnt_next_s = drain_cnt_r;
        pc_wren_s        = 1'b0;
        ifid_s           = STAGE_HOLD;
        idex_s           = STAGE_HOLD;
        exmem_s          = STAGE_HOLD;
        memwb_s          = STAGE_HOLD;

        if (rst) begin
            // Controls stay quiet while reset is applied, even between edges.
            state_next_s = RUN;
        end else begin
            case (state_r)
                RUN: begin
                    pc_wren_s = 1'b1;
                    ifid_s    = STAGE_RUN;
                    idex_s    = STAGE_RUN;
                    exmem_s   = STAGE_RUN;
                    memwb_s   = STAGE_RUN;
                    if (dcache_miss) begin
                        pc_wren_s = 1'b0;
                        ifid_s    = STAGE_HOLD;
                        idex_s    = STAGE_HOLD;
                        exmem_s   = STAGE_HOLD;
                        memwb_s   = STAGE_HOLD;
                    end else if (load_use_s) begin
                        // Hold IF/ID and PC, inject a bubble into ID/EX; branch/halt re-evaluate next cycle.
                        pc_wren_s = 1'b0;
                        ifid_s    = mk_stage(1'b0, 1'b0);
                        idex_s    = STAGE_BUBBLE;
                    end else if (id_branch_taken) begin
                        // Redirect wins over a pending I-cache miss.
                        pc_wren_s = 1'b1;
                        ifid_s    = STAGE_BUBBLE;
                    end else if (id_halt) begin
                        pc_wren_s        = 1'b0;
                        ifid_s           = STAGE_BUBBLE;
                        state_next_s     = DRAIN;
                        drain_cnt_next_s = DRAIN_W'(DRAIN_CYCLES);
                    end else if (icache_miss) begin
                        pc_wren_s = 1'b0;
                        ifid_s    = STAGE_BUBBLE;
                    end else begin
                        pc_wren_s = 1'b1;
                    end
                end
                DRAIN: begin
                    if (dcache_miss) begin
                        // Full freeze: counter holds so the HLT still gets its three back-end cycles.
                        pc_wren_s = 1'b0;
                    end else begin
                        pc_wren_s = 1'b0;
                        ifid_s    = STAGE_BUBBLE;
                        idex_s    = STAGE_RUN;
                        exmem_s   = STAGE_RUN;
                        memwb_s   = STAGE_RUN;
                        if (drain_cnt_r == DRAIN_W'(1)) begin
                            state_next_s     = HALTED;
                            drain_cnt_next_s = {DRAIN_W{1'b0}};
                        end else begin
                            drain_cnt_next_s = drain_cnt_r - DRAIN_W'(1);
                        end
                    end
                end
                HALTED: begin
                    state_next_s = HALTED;
                end
                default: begin
                    state_next_s = RUN;
                end
            endcase
        end
    end

    // State, drain counter and saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= RUN;
            drain_cnt_r   <= {DRAIN_W{1'b0}};
            stall_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_next_s;
            drain_cnt_r <= drain_cnt_next_s;
            if (!pc_wren_s && (state_r != HALTED) && (stall_count_r != {CNT_W{1'b1}})) begin
                stall_count_r <= stall_count_r + CNT_W'(1);
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    assign pc_wren     = pc_wren_s;
    assign ifid_wren   = ifid_s.wren;
    assign ifid_clr    = ifid_s.clr;
    assign idex_wren   = idex_s.wren;
    assign idex_clr    = idex_s.clr;
    assign exmem_wren  = exmem_s.wren;
    assign exmem_clr   = exmem_s.clr;
    assign memwb_wren  = memwb_s.wren;
    assign memwb_clr   = memwb_s.clr;
    assign halted      = (state_r == HALTED);
    assign stall_count = stall_count_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: single-cycle vector table plus
// hand-written multi-cycle sequences; expected outputs go through a queue.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  id_rs = 4'd0, id_rt = 4'd0, ex_rd = 4'd0;
    logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_mem_read = 1'b0;
    logic        id_branch_taken = 1'b0, id_halt = 1'b0;
    logic        icache_miss = 1'b0, dcache_miss = 1'b0;
    logic        pc_wren, ifid_wren, ifid_clr, idex_wren, idex_clr;
    logic        exmem_wren, exmem_clr, memwb_wren, memwb_clr, halted;
    logic [15:0] stall_count;

    pipeline_ctrl #(.REG_ADDR_W(4), .DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .id_branch_taken(id_branch_taken), .id_halt(id_halt),
        .icache_miss(icache_miss), .dcache_miss(dcache_miss),
        .pc_wren(pc_wren), .ifid_wren(ifid_wren), .ifid_clr(ifid_clr),
        .idex_wren(idex_wren), .idex_clr(idex_clr),
        .exmem_wren(exmem_wren), .exmem_clr(exmem_clr),
        .memwb_wren(memwb_wren), .memwb_clr(memwb_clr),
        .halted(halted), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Output vector: {pc, ifid_w, ifid_c, idex_w, idex_c, exmem_w, exmem_c, memwb_w, memwb_c, halted}
    localparam logic [9:0] O_RUN   = 10'b1_10_10_10_10_0;
    localparam logic [9:0] O_FRZ   = 10'b0_00_00_00_00_0;
    localparam logic [9:0] O_LU    = 10'b0_00_11_10_10_0;
    localparam logic [9:0] O_BR    = 10'b1_11_10_10_10_0;
    localparam logic [9:0] O_FLUSH = 10'b0_11_10_10_10_0; // halt/icache/drain
    localparam logic [9:0] O_HLT   = 10'b0_00_00_00_00_1;

    typedef struct packed {
        logic [3:0] rs; logic [3:0] rt; logic urs; logic urt;
        logic mr; logic [3:0] rd; logic br; logic hlt; logic ic; logic dc;
    } in_t;

    typedef struct packed { in_t in; logic [9:0] exp; } vec_t;

    localparam in_t I_IDLE = '{rs: 4'd0, rt: 4'd0, urs: 1'b0, urt: 1'b0, mr: 1'b0,
                               rd: 4'd0, br: 1'b0, hlt: 1'b0, ic: 1'b0, dc: 1'b0};

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [9:0]  exp_q[$];

    function automatic logic [9:0] got_vec();
        return {pc_wren, ifid_wren, ifid_clr, idex_wren, idex_clr,
                exmem_wren, exmem_clr, memwb_wren, memwb_clr, halted};
    endfunction

    task automatic chk10(input string nm, input logic [9:0] got, input logic [9:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", nm, got, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic drive(input in_t s);
        id_rs = s.rs; id_rt = s.rt; id_uses_rs = s.urs; id_uses_rt = s.urt;
        ex_mem_read = s.mr; ex_rd = s.rd; id_branch_taken = s.br;
        id_halt = s.hlt; icache_miss = s.ic; dcache_miss = s.dc;
    endtask

    // One cycle: called just after a posedge; checks before the next posedge.
    task automatic step(input in_t s, input logic [9:0] e, input string nm);
        logic [9:0] want;
        drive(s);
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            want = exp_q.pop_front();
            chk10({nm, " ctl"}, got_vec(), want);
        end
        chk16({nm, " cnt"}, stall_count, exp_cnt);
        if (!e[9] && !e[0] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        @(posedge clk); #1;
    endtask

    // Assert reset between edges, check it acts immediately, release mid-cycle.
    task automatic async_reset(input string nm);
        drive(I_IDLE);
        #2 rst = 1'b1;
        #1;
        chk10({nm, " ctl"}, got_vec(), 10'b0);
        chk16({nm, " cnt"}, stall_count, 16'd0);
        exp_q.delete();
        exp_cnt = 16'd0;
        @(posedge clk); #2 rst = 1'b0;
    endtask

    vec_t vt[12];
    in_t  lu;

    initial begin
        lu = I_IDLE; lu.mr = 1'b1; lu.rd = 4'd3; lu.rs = 4'd3; lu.urs = 1'b1;

        vt[0]  = '{in: I_IDLE, exp: O_RUN};
        vt[1]  = '{in: lu, exp: O_LU};
        vt[2]  = '{in: '{rs: 4'd0, rt: 4'd0, urs: 1'b1, urt: 1'b1, mr: 1'b1, rd: 4'd0,
                         br: 1'b0, hlt: 1'b0, ic: 1'b0, dc: 1'b0}, exp: O_RUN};
        vt[3]  = '{in: '{rs: 4'd1, rt: 4'd5, urs: 1'b1, urt: 1'b1, mr: 1'b1, rd: 4'd5,
                         br: 1'b0, hlt: 1'b0, ic: 1'b0, dc: 1'b0}, exp: O_LU};
        vt[4]  = '{in: '{rs: 4'd1, rt: 4'd5, urs: 1'b1, urt: 1'b0, mr: 1'b1, rd: 4'd5,
                         br: 1'b0, hlt: 1'b0, ic: 1'b0, dc: 1'b0}, exp: O_RUN};
        vt[5]  = '{in: '{rs: 4'd3, rt: 4'd0, urs: 1'b1, urt: 1'b0, mr: 1'b0, rd: 4'd3,
                         br: 1'b0, hlt: 1'b0, ic: 1'b0, dc: 1'b0}, exp: O_RUN};
        vt[6]  = '{in: '{rs: 4'd0, rt: 4'd0, urs: 1'b0, urt: 1'b0, mr: 1'b0, rd: 4'd0,
                         br: 1'b1, hlt: 1'b0, ic: 1'b1, dc: 1'b0}, exp: O_BR};
        vt[7]  = '{in: '{rs: 4'd0, rt: 4'd0, urs: 1'b0, urt: 1'b0, mr: 1'b0, rd: 4'd0,
                         br: 1'b0, hlt: 1'b0, ic: 1'b1, dc: 1'b0}, exp: O_FLUSH};
        vt[8]  = '{in: '{rs: 4'd0, rt: 4'd0, urs: 1'b0, urt: 1'b0, mr: 1'b0, rd: 4'd0,
                         br: 1'b0, hlt: 1'b0, ic: 1'b0, dc: 1'b1}, exp: O_FRZ};
        vt[9]  = '{in: '{rs: 4'd3, rt: 4'd0, urs: 1'b1, urt: 1'b0, mr: 1'b1, rd: 4'd3,
                         br: 1'b1, hlt: 1'b0, ic: 1'b0, dc: 1'b0}, exp: O_LU};
        vt[10] = '{in: '{rs: 4'd3, rt: 4'd0, urs: 1'b1, urt: 1'b0, mr: 1'b1, rd: 4'd3,
                         br: 1'b0, hlt: 1'b1, ic: 1'b0, dc: 1'b0}, exp: O_LU};
        vt[11] = '{in: '{rs: 4'd0, rt: 4'd0, urs: 1'b0, urt: 1'b0, mr: 1'b0, rd: 4'd0,
                         br: 1'b1, hlt: 1'b0, ic: 1'b0, dc: 1'b1}, exp: O_FRZ};

        // Reset state.
        drive(I_IDLE);
        @(negedge clk);
        chk10("reset ctl", got_vec(), 10'b0);
        chk16("reset cnt", stall_count, 16'd0);
        @(posedge clk); #2 rst = 1'b0;

        // Single-cycle vectors in RUN.
        for (int i = 0; i < 12; i++) step(vt[i].in, vt[i].exp, $sformatf("vec%0d", i));

        // D-cache miss dominating a held load-use for four cycles.
        lu.dc = 1'b1;
        for (int i = 0; i < 4; i++) step(lu, O_FRZ, $sformatf("dfrz%0d", i));
        lu.dc = 1'b0;
        step(lu, O_LU, "dfrz_lu");
        step(I_IDLE, O_RUN, "dfrz_run");

        // Halt drain without interruption; branch in HALTED ignored.
        step('{rs: 4'd0, rt: 4'd0, urs: 1'b0, urt: 1'b0, mr: 1'b0, rd: 4'd0,
               br: 1'b0, hlt: 1'b1, ic: 1'b1, dc: 1'b0}, O_FLUSH, "halt");
        for (int i = 0; i < 3; i++) step(I_IDLE, O_FLUSH, $sformatf("drainA%0d", i));
        step(I_IDLE, O_HLT, "haltedA0");
        step('{rs: 4'd0, rt: 4'd0, urs: 1'b0, urt: 1'b0, mr: 1'b0, rd: 4'd0,
               br: 1'b1, hlt: 1'b0, ic: 1'b0, dc: 1'b0}, O_HLT, "haltedA1");
        async_reset("rst_halted");
        step(I_IDLE, O_RUN, "post_rst");

        // Reset mid-drain returns straight to RUN.
        step('{rs: 4'd0, rt: 4'd0, urs: 1'b0, urt: 1'b0, mr: 1'b0, rd: 4'd0,
               br: 1'b0, hlt: 1'b1, ic: 1'b0, dc: 1'b0}, O_FLUSH, "haltM");
        step(I_IDLE, O_FLUSH, "drainM0");
        async_reset("rst_drain");
        step(I_IDLE, O_RUN, "post_rst_drain");

        // Halt drain with a D-cache freeze in the second drain cycle.
        step('{rs: 4'd0, rt: 4'd0, urs: 1'b0, urt: 1'b0, mr: 1'b0, rd: 4'd0,
               br: 1'b0, hlt: 1'b1, ic: 1'b0, dc: 1'b0}, O_FLUSH, "haltB");
        step(I_IDLE, O_FLUSH, "drainB0");
        step('{rs: 4'd0, rt: 4'd0, urs: 1'b0, urt: 1'b0, mr: 1'b0, rd: 4'd0,
               br: 1'b0, hlt: 1'b0, ic: 1'b0, dc: 1'b1}, O_FRZ, "drainB1_frz");
        step(I_IDLE, O_FLUSH, "drainB2");
        step(I_IDLE, O_FLUSH, "drainB3");
        step(I_IDLE, O_HLT, "haltedB");

        // Saturation: 2^16+5 I-cache miss cycles.
        async_reset("rst_sat");
        icache_miss = 1'b1;
        repeat (65541) @(posedge clk);
        @(negedge clk);
        chk16("sat cnt", stall_count, 16'hFFFF);
        exp_cnt = 16'hFFFF;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step(vt[7].in, O_FLUSH, $sformatf("sat_hold%0d", i));
        step('{rs: 4'd0, rt: 4'd0, urs: 1'b0, urt: 1'b0, mr: 1'b0, rd: 4'd0,
               br: 1'b0, hlt: 1'b1, ic: 1'b0, dc: 1'b0}, O_FLUSH, "haltS");
        for (int i = 0; i < 3; i++) step(I_IDLE, O_FLUSH, $sformatf("drainS%0d", i));
        step(I_IDLE, O_HLT, "haltedS");
        async_reset("rst_final");
        step(I_IDLE, O_RUN, "final_run");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
